// File: rtl/irq_source.sv
// irq_source: per-channel interrupt sources, each with a pending-event counter and a REQ/SVC handshake FSM.
// Define IRQ_TIMER_EN to add a periodic channel-0 tick driven by timer_period.

module irq_chan #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic tick,
  input  logic armed,
  input  logic irw,
  output logic irq,
  output logic busy,
  output logic overflow
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic [1:0] {IDLE, REQ, SVC, GAP} state_t;

  state_t           state, state_nx;
  logic [1:0]       sync;
  logic             prev, ev, dec, ovf_set;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [TW-1:0]    tcnt;

  always_comb begin
    state_nx = state;
    dec      = 1'b0;
    case (state)
      IDLE: if (cnt != '0) state_nx = REQ;
      // IRW wins over a timeout expiring on the same edge
      REQ:  if (irw) state_nx = SVC;
            else if (tcnt == TW'(TIMEOUT - 1)) state_nx = GAP;
      SVC:  if (!irw) begin
              state_nx = IDLE;
              dec      = 1'b1;
            end
      GAP:  state_nx = REQ;
      default: state_nx = IDLE;
    endcase

    cnt_nx  = cnt;
    ovf_set = 1'b0;
    if (ev && !dec) begin
      if (cnt == CMAX) ovf_set = 1'b1;
      else             cnt_nx  = cnt + 1'b1;
    end else if (dec && !ev) begin
      cnt_nx = cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync     <= '0;
      prev     <= 1'b0;
      ev       <= 1'b0;
      state    <= IDLE;
      cnt      <= '0;
      tcnt     <= '0;
      irq      <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      sync     <= {sync[0], src};
      prev     <= sync[1];
      ev       <= (sync[1] & ~prev & armed) | tick;
      state    <= state_nx;
      cnt      <= cnt_nx;
      tcnt     <= (state == REQ && state_nx == REQ) ? tcnt + 1'b1 : '0;
      irq      <= (state_nx == REQ);
      busy     <= (cnt_nx != '0) || (state_nx != IDLE);
      overflow <= overflow | ovf_set;
    end
  end
endmodule

module irq_source #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  src,
  input  logic [2:0]  IRW,
  input  logic [15:0] timer_period,
  output logic [2:0]  IRQ,
  output logic [2:0]  busy,
  output logic [2:0]  overflow
);
  localparam int NUM_CH = 3;

  logic [1:0] arm;
  logic       armed;
  logic       tick;

  // Edges are suppressed until the synchronizers have filled after reset,
  // so a source already high at release does not look like a rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) arm <= '0;
    else if (arm != 2'd3) arm <= arm + 2'd1;
  end
  assign armed = (arm == 2'd3);

`ifdef IRQ_TIMER_EN
  logic [15:0] tmr;

  assign tick = (tmr == 16'd1);

  // New periods are picked up only on reload (or start from stopped)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           tmr <= '0;
    else if (timer_period == 16'd0)     tmr <= '0;
    else if (tmr == 16'd0 || tmr == 16'd1) tmr <= timer_period;
    else                                tmr <= tmr - 16'd1;
  end
`else
  logic unused_period;

  assign tick          = 1'b0;
  assign unused_period = ^timer_period;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    irq_chan #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .src      (src[i]),
      .tick     ((i == 0) ? tick : 1'b0),
      .armed    (armed),
      .irw      (IRW[i]),
      .irq      (IRQ[i]),
      .busy     (busy[i]),
      .overflow (overflow[i])
    );
  end
endmodule

// File: doc/irq_source.md
IRQ_SOURCE -- requirements
Module: irq_source

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 1024, giving the cycles IRQ stays high awaiting IRW before a retry.
REQ-002 The block SHALL have parameter CNT_W, default 3, giving the width of each channel's pending counter.
REQ-003 The block SHALL have port clk  in  1  single clock, rising-edge.
REQ-004 The block SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port src  in  3  raw per-channel trigger levels (buttons, peripherals), asynchronous to clk.
REQ-006 The block SHALL have port IRW  in  3  CPU per-channel "request latched, awaiting service" flags.
REQ-007 The block SHALL have port timer_period  in  16  channel-0 periodic tick period in cycles; 0 disables the tick.
REQ-008 The block SHALL have port IRQ  out  3  per-channel interrupt request to the CPU, registered.
REQ-009 The block SHALL have port busy  out  3  per-channel flag, high when that channel's pending count is nonzero or its FSM is not IDLE.
REQ-010 The block SHALL have port overflow  out  3  per-channel sticky flag, set when an event arrives while the pending count is saturated.

Function
REQ-011 Each src bit SHALL pass through a 2-flop synchronizer, then a rising-edge detector, giving a one-cycle event per rising edge.
REQ-012 A rising edge on src sampled at edge k SHALL increment that channel's pending count at edge k+3.
REQ-013 The pending count SHALL be unsigned CNT_W bits and SHALL saturate at 2^CNT_W-1; an event at saturation SHALL leave the count unchanged and set overflow.
REQ-014 An increment and a decrement in the same cycle SHALL leave the count unchanged.
REQ-015 Each channel SHALL run an independent FSM with states IDLE, REQ, SVC and GAP.
REQ-016 IDLE -> REQ SHALL occur on the edge where count != 0; IRQ SHALL be high exactly while the state is REQ.
REQ-017 REQ -> SVC SHALL occur on the first edge with IRW[i]=1.
REQ-018 SVC SHALL hold IRQ low; SVC -> IDLE SHALL occur on the first edge with IRW[i]=0 and SHALL decrement the count on that same edge.
REQ-019 If REQ lasts TIMEOUT cycles without IRW[i]=1, REQ -> GAP SHALL occur; GAP SHALL hold IRQ low for exactly 1 cycle and then return to REQ; the count SHALL be unchanged.
REQ-020 If IRW[i]=1 and the timeout expire on the same edge, the IRW transition SHALL take priority.
REQ-021 IRW[i]=1 observed in IDLE or GAP SHALL be ignored.
REQ-022 Back-to-back service SHALL follow from the FSM: with the count still nonzero after a decrement, IRQ SHALL re-assert the cycle after SVC -> IDLE.
REQ-023 Channels SHALL NOT interact; prioritisation belongs to the CPU.
REQ-024 busy and overflow SHALL be registered outputs.

Reset
REQ-025 While rst=0, IRQ, busy and overflow SHALL be 0; all FSMs SHALL be IDLE; counts, synchronizers, edge registers, timeout counters and the tick timer SHALL be 0.
REQ-026 Reset asserted mid-operation SHALL abort immediately; in-flight and pending events SHALL be lost.
REQ-027 After rst deasserts, a src held high SHALL NOT generate an event; only a later rising edge counts.
REQ-028 overflow SHALL clear only on reset.

Configuration
REQ-029 With macro IRQ_TIMER_EN defined, a 16-bit down-counter SHALL load timer_period and decrement each cycle.
REQ-030 With IRQ_TIMER_EN defined, on reaching 1 the counter SHALL produce a channel-0 event and reload.
REQ-031 With IRQ_TIMER_EN defined, a tick and a src[0] edge in the same cycle SHALL count as one event.
REQ-032 With IRQ_TIMER_EN defined, timer_period=0 SHALL stop the counter, and a change of timer_period SHALL take effect at the next reload.
REQ-033 Without IRQ_TIMER_EN, timer_period SHALL remain a port but SHALL be ignored, and no tick logic SHALL exist.

Verification
REQ-034 src[1] pulse 0->1 at edge 10 with the CPU model raising IRW[1] 2 cycles after IRQ[1] and dropping it 20 cycles later -> IRQ[1] high from edge 14 to 16; count 1->0 when IRW[1] falls; busy[1] then 0.
REQ-035 Nine src[2] edges before any service (CNT_W=3) -> count saturates at 7, overflow[2]=1, and exactly 7 handshakes are completed.
REQ-036 IRW held 0 with TIMEOUT=8 -> IRQ[0] pattern is 8 high, 1 low, repeating; count stays 1.
REQ-037 rst pulled low while IRQ[1]=1 and count=3 -> IRQ, busy and count are 0 immediately; src[1] held high through release gives no event.
REQ-038 With IRQ_TIMER_EN and timer_period=100 -> channel-0 events every 100 cycles; with the macro undefined -> no IRQ[0] activity.
REQ-039 Simultaneous src[0] event and SVC -> IDLE at count=2 -> count stays 2 and IRQ[0] re-asserts next cycle.
